// File: rtl/cam_sensor_emu.sv
// cam_sensor_emu
//   Camera-side transmitter emulating an OV7670-style sensor in VGA RGB444
//   mode. It produces PCLK, VSYNC, HREF and a byte stream carrying a
//   selectable test pattern, so the pixel extractor can be exercised in
//   loopback without a physical sensor.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   enable     in   run request, sampled only at frame boundaries
//   mode[1:0]  in   pattern: 0 const, 1 h-ramp, 2 h-ramp+frame, 3 colour bars
//   pclk       out  pixel byte clock (2*PCLK_HALF clk per period)
//   vsync      out  frame sync, active high
//   href       out  line valid, active high
//   pixdata    out  byte stream, two bytes per RGB444 pixel
//   frame_cnt  out  completed frames, wraps at 255
//   frame_done out  one-clk pulse at the end of each frame
//   busy       out  high while a frame is in progress

module cam_sensor_emu #(
    parameter int unsigned PCLK_HALF = 1,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_BLANK   = 144,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 17,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter logic [11:0] CONST_PIX = 12'h064
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] pixdata,
    output logic [7:0] frame_cnt,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned H_TOT = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned VW1   = VW + 1;
    localparam int unsigned DW    = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DW-1:0] r_div;
    logic          r_pclk;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [1:0]    r_mode;
    logic          r_vsync;
    logic          r_href;
    logic [7:0]    r_pixdata;
    logic [7:0]    r_frame_cnt;
    logic          r_frame_done;

    logic          w_toggle;
    logic          w_tick;
    logic          w_hlast;
    logic          w_vlast;
    logic          w_frame_end;
    logic          w_vsync;
    logic          w_href;
    logic          w_vact;
    logic [12:0]   w_hoff;
    logic [11:0]   w_pix;
    logic [14:0]   w_bar_num;
    logic [2:0]    w_bar;
    logic [11:0]   w_pval;
    logic [7:0]    w_pixdata;

    // Prescaler: the tick is the clk edge on which pclk falls.
    assign w_toggle    = (r_div == DW'(PCLK_HALF - 1));
    assign w_tick      = (r_state == S_RUN) && r_pclk && w_toggle;
    assign w_hlast     = (r_hcnt == HW'(H_TOT - 1));
    assign w_vlast     = (r_vcnt == VW'(V_TOT - 1));
    assign w_frame_end = w_tick && w_hlast && w_vlast;

    // Pixel/sync decode of the current counter position; registered on the tick.
    assign w_vsync   = ({1'b0, r_vcnt} < VW1'(V_SYNC));
    assign w_href    = (r_hcnt >= HW'(H_BLANK));
    assign w_vact    = ({1'b0, r_vcnt} >= VW1'(V_SYNC + V_BACK)) &&
                       ({1'b0, r_vcnt} <  VW1'(V_SYNC + V_BACK + V_ACTIVE));
    assign w_hoff    = 13'(r_hcnt) - 13'(H_BLANK);
    assign w_pix     = w_hoff[12:1];
    assign w_bar_num = {w_pix, 3'b000};
    assign w_bar     = 3'(w_bar_num / 15'(H_ACTIVE / 2));

    always_comb begin
        w_pval = CONST_PIX;
        case (r_mode)
            2'd0:    w_pval = CONST_PIX;
            2'd1:    w_pval = w_pix;
            2'd2:    w_pval = w_pix + {4'h0, r_frame_cnt};
            default: w_pval = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
        endcase
    end

    always_comb begin
        w_pixdata = '0;
        if (w_href && w_vact) begin
            // Even byte of a pair carries R, odd byte carries {G, B}.
            w_pixdata = w_hoff[0] ? w_pval[7:0] : {4'h0, w_pval[11:8]};
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_frame_end && !enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_pclk       <= 1'b0;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_mode       <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_pixdata    <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_div        <= '0;
            r_pclk       <= 1'b0;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_pixdata    <= '0;
            r_frame_done <= 1'b0;
            if (enable) begin
                r_mode <= mode;
            end
        end else begin
            r_frame_done <= w_frame_end;
            if (w_toggle) begin
                r_div  <= '0;
                r_pclk <= ~r_pclk;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_tick) begin
                r_vsync   <= w_vsync;
                r_href    <= w_href;
                r_pixdata <= w_pixdata;
                if (w_hlast) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_vlast ? '0 : r_vcnt + 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
                if (w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                    // Mode for a back-to-back frame is taken at the boundary.
                    r_mode      <= mode;
                end
            end
        end
    end

    assign pclk       = r_pclk;
    assign vsync      = r_vsync;
    assign href       = r_href;
    assign pixdata    = r_pixdata;
    assign frame_cnt  = r_frame_cnt;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == S_RUN);

endmodule

// File: tb/tb_cam_sensor_emu.sv
// Bench for cam_sensor_emu with a reduced frame geometry. A reference model
// derives each transmitted byte from its position in the frame.

module tb_cam_sensor_emu;

    localparam int unsigned PH = 2;
    localparam int unsigned HA = 32;
    localparam int unsigned HB = 6;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 2;
    localparam int unsigned VA = 4;
    localparam int unsigned VF = 2;
    localparam logic [11:0] CPIX = 12'h064;
    localparam int unsigned HT = HA + HB;
    localparam int unsigned VT = VS + VB + VA + VF;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned FRAME_CLK = FRAME * 2 * PH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       pclk, vsync, href, frame_done, busy;
    logic [7:0] pixdata, frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: byte index within the frame and frames completed.
    int unsigned k = 0;
    int unsigned frames = 0;
    int unsigned done_pulses = 0;
    int unsigned since_fall = 0;
    logic        prev_pclk = 1'b0;
    logic        rst_q = 1'b1;
    logic [1:0]  frame_mode = 2'd0;

    cam_sensor_emu #(
        .PCLK_HALF(PH),
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .CONST_PIX(CPIX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .pclk      (pclk),
        .vsync     (vsync),
        .href      (href),
        .pixdata   (pixdata),
        .frame_cnt (frame_cnt),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {vsync, href, pixdata} for byte idx of a frame.
    function automatic logic [9:0] exp_byte(input int unsigned idx, input int unsigned fc,
                                            input logic [1:0] md);
        int unsigned h, v, x, p, b, pv;
        logic        vs_e, hr_e;
        logic [7:0]  pd;
        h    = idx % HT;
        v    = idx / HT;
        vs_e = (v < VS);
        hr_e = (h >= HB);
        pd   = 8'h00;
        pv   = 0;
        if (hr_e && v >= VS + VB && v < VS + VB + VA) begin
            x = h - HB;
            p = x / 2;
            case (md)
                2'd0: pv = CPIX;
                2'd1: pv = p % 4096;
                2'd2: pv = (p + fc) % 4096;
                default: begin
                    b  = p * 8 / (HA / 2);
                    pv = ((b / 4) % 2) * 'hF00 + ((b / 2) % 2) * 'h0F0 + (b % 2) * 'h00F;
                end
            endcase
            pd = (x % 2 == 0) ? 8'(pv / 256) : 8'(pv % 256);
        end
        return {vs_e, hr_e, pd};
    endfunction

    // Monitor: every pclk fall presents the next byte of the frame.
    always @(negedge clk) begin : mon
        logic fall;
        logic last;
        since_fall++;
        if (rst_q) begin
            k           = 0;
            frames      = 0;
            done_pulses = 0;
            prev_pclk   = 1'b0;
        end else begin
            fall = prev_pclk && !pclk;
            last = fall && (k == FRAME - 1);
            if (frame_done) done_pulses++;
            if (frame_done || last) check("frame_done", frame_done, last);
            if (fall) begin
                if (k == 0) frame_mode = mode;
                else check("pclk_period", since_fall, 2 * PH);
                check("byte", {vsync, href, pixdata}, exp_byte(k, frames % 256, frame_mode));
                if (last) begin
                    frames++;
                    k = 0;
                    check("frame_cnt", frame_cnt, frames % 256);
                    check("busy_end", busy, enable);
                end else begin
                    k++;
                    check("frame_cnt", frame_cnt, frames % 256);
                    check("busy", busy, 1);
                end
                since_fall = 0;
            end
            prev_pclk = pclk;
        end
    end

    task automatic wait_k(input int unsigned tgt);
        int unsigned n = 0;
        while (k < tgt && n < 2 * FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        if (k < tgt) check("timeout_k", k, tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        @(negedge clk);
        while (!frame_done && n < 2 * FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", frame_done, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned mid_point();
        return $urandom_range(3 * FRAME / 4, FRAME / 4);
    endfunction

    initial begin : stim
        int unsigned tgt;
        rst    = 1'b1;
        enable = 1'b0;
        mode   = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", {pclk, vsync, href, pixdata, frame_cnt, frame_done, busy}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("idle", {pclk, busy, vsync, href}, 0);
        end

        // Frame 0 constant; a mid-frame mode change applies to frame 1.
        @(posedge clk);
        #1;
        mode   = 2'd0;
        enable = 1'b1;
        wait_k(mid_point());
        mode = 2'd1;
        wait_done();

        // Frame 1: drop enable mid-frame, it still runs to completion.
        wait_k(mid_point());
        mode   = 2'd2;
        enable = 1'b0;
        wait_done();
        check("frame_cnt_stop", frame_cnt, 2);
        repeat (8 * PH) begin
            @(negedge clk);
            check("idle_pclk", {pclk, busy}, 0);
        end

        // Restart: frame 2 in mode 2 with frame_cnt=2, then a random mix.
        @(posedge clk);
        #1 enable = 1'b1;
        for (int f = 2; f < 7; f++) begin
            wait_k(mid_point());
            mode = (f == 2) ? 2'd3 : 2'($urandom_range(3, 0));
            wait_done();
        end

        // Reset in the middle of an active line, held for 3 clk.
        tgt = (VS + VB + $urandom_range(VA - 1, 0)) * HT + HB + $urandom_range(HA - 1, 0);
        wait_k(tgt);
        rst  = 1'b1;
        mode = 2'($urandom_range(3, 0));
        @(posedge clk);
        @(negedge clk);
        check("reset_mid", {pclk, vsync, href, pixdata, frame_cnt, frame_done, busy}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        wait_k(mid_point());
        enable = 1'b0;
        wait_done();
        check("frame_cnt_after_rst", frame_cnt, 1);
        repeat (4) @(negedge clk);
        check("idle_after_rst", {pclk, busy}, 0);
        check("done_pulses", done_pulses, frames);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_sensor_emu.md
Name: cam_sensor_emu

Overview:
- Synthesizable camera-side transmitter for the pixel-extraction path.
- Generates PCLK, VSYNC, HREF and an 8-bit byte stream with OV7670-style VGA timing: 784 byte-clocks per line, 510 lines per frame, two bytes per RGB444 pixel.
- Drives the pixel extractor's camera inputs in FPGA loopback and in benches, so frames are self-checking and need no physical sensor.

Parameters:
- PCLK_HALF, 1, clk cycles per PCLK half-period (PCLK period = 2*PCLK_HALF clk).
- H_ACTIVE, 640, bytes per active line (HREF high), = 2 * pixels.
- H_BLANK, 144, byte-clocks per line with HREF low.
- V_SYNC, 3, lines with VSYNC high at frame start.
- V_BACK, 17, lines after VSYNC before the first active line.
- V_ACTIVE, 480, active lines.
- V_FRONT, 10, lines after the last active line.
- CONST_PIX, 12'h064, pixel value for pattern mode 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run request; sampled only at frame boundary
- mode  in  2  pattern: 0 const, 1 h-ramp, 2 h-ramp+frame, 3 colour bars
- pclk  out  1  pixel byte clock
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- pixdata  out  8  byte stream
- frame_cnt  out  8  completed frames, wraps at 255
- frame_done  out  1  one-clk pulse at end of each frame
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset values (rst high at a clk edge): pclk=0, vsync=0, href=0, pixdata=0, frame_cnt=0, frame_done=0, busy=0. All counters clear.
- Reset mid-frame aborts the frame immediately. The next frame starts from line 0, byte 0.
- PCLK:
  - A prescaler toggles pclk every PCLK_HALF clk cycles while busy. pclk is held 0 when idle.
  - The 1->0 transition of pclk is the "tick".
- Registered-output timing:
  - All of vsync, href and pixdata update on the same clk edge that drives pclk 0.
  - They are therefore stable across the following pclk rising edge, where the receiver samples.
- Counters:
  - hcnt runs 0..H_ACTIVE+H_BLANK-1; vcnt runs 0..V_SYNC+V_BACK+V_ACTIVE+V_FRONT-1.
  - Both advance on each tick; hcnt wraps and increments vcnt.
- States:
  - IDLE: pclk held 0. Go to RUN when enable=1.
  - RUN: one frame.
  - At the last tick of the frame (hcnt and vcnt both at max), pulse frame_done for one clk and increment frame_cnt (wraps 255->0).
  - Then stay in RUN if enable=1 (no gap between frames), else go to IDLE.
  - Deasserting enable mid-frame has no effect until the frame ends.
- Sync outputs:
  - vsync = 1 while vcnt < V_SYNC.
  - href is driven purely from hcnt, as on the sensor: href = 1 while hcnt >= H_BLANK. Each line is H_BLANK blank byte-clocks followed by H_ACTIVE active byte-clocks. href also toggles during sync, back-porch and front-porch lines.
  - Active line = V_SYNC+V_BACK <= vcnt < V_SYNC+V_BACK+V_ACTIVE.
- pixdata:
  - 0 whenever href=0 or the line is not active.
  - On active bytes: p = (hcnt-H_BLANK)>>1 is the pixel index; the first byte of a pair is {4'h0, R}, the second is {G, B}, where {R,G,B} is a 12-bit value P.
- P by mode:
  - 0: CONST_PIX.
  - 1: p[11:0].
  - 2: (p + frame_cnt) mod 4096.
  - 3: bar b = p*8/(H_ACTIVE/2), giving 0..7. R = {4{b[2]}}, G = {4{b[1]}}, B = {4{b[0]}}.
- mode is sampled at frame start and held for the whole frame.
- busy = 1 in RUN.

Test Plan:
- Reset mid-frame:
  - Stimulus: rst asserted during an active line, held 3 clk.
  - Response: next clk all outputs 0, state IDLE, frame_cnt=0; after release with enable=1, vsync=1 at the first tick.
- Default timing:
  - Stimulus: PCLK_HALF=1, enable=1, mode=0, one frame.
  - Response:
    - vsync high exactly 3*784=2352 pclk periods.
    - Every line: href low 144 pclk, then high 640 pclk.
    - Frame length 510*784=399840 pclk periods.
    - frame_done pulses once; frame_cnt=1.
- Constant mode:
  - Stimulus: mode=0.
  - Response: on active lines the bytes alternate 8'h00, 8'h64. 320 pairs per line, 480 lines.
- Ramp mode:
  - Stimulus: mode=1.
  - Response: pixel 5 = bytes 8'h00, 8'h05; pixel 300 = bytes 8'h01, 8'h2C.
  - Stimulus: mode=2, third frame (frame_cnt=2).
  - Response: pixel 0 = bytes 8'h00, 8'h02.
- Colour bars:
  - Stimulus: mode=3.
  - Response: pixels 0..39 give bytes 00,00; pixels 280..319 give 0F,FF; pixel 120 (bar 3) gives 00,FF.
- Enable and mode timing:
  - Stimulus: drop enable mid-frame 2.
  - Response: frame 2 completes in full and frame_cnt=2; busy falls after frame_done; pclk then stays 0.
  - Stimulus: change mode mid-frame.
  - Response: no effect until the next frame.
